extract_multibeat: RTL and testbench

- Generalised header extractor for handler pipelines.
- Captures a struct of EXTRACTED_STRUCT_WIDTH bits starting at byte EXTRACT_OFFSET of each packet. The struct may span several bus beats.
- Forwards the full packet unmodified on the buffer output.
- Queues one struct per packet in an internal FIFO, so the buffer path keeps flowing while the struct consumer is slow.

---
 rtl/extract_multibeat.sv | 205 ++++++++++++++++++++
 tb/tb_extract_multibeat.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/extract_multibeat.sv
// Header extractor: captures a multi-beat struct at a fixed byte offset of each packet
// and queues it in a FWFT FIFO. Optional macro EXTRACT_LEN_CHECK_EN adds a short-packet flag and counter.
module extract_multibeat #(
  parameter int BUF_DATA_WIDTH         = 512,
  parameter int BUF_KEEP_WIDTH         = BUF_DATA_WIDTH/8,
  parameter int EXTRACTED_STRUCT_WIDTH = 160,
  parameter int EXTRACT_OFFSET         = 0,
  parameter int STRUCT_FIFO_DEPTH      = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [BUF_DATA_WIDTH-1:0]         s_inbuf_axis_tdata,
  input  logic [BUF_KEEP_WIDTH-1:0]         s_inbuf_axis_tkeep,
  input  logic                              s_inbuf_axis_tlast,
  input  logic                              s_inbuf_axis_tvalid,
  output logic                              s_inbuf_axis_tready,
  output logic [BUF_DATA_WIDTH-1:0]         m_outbuf_axis_tdata,
  output logic [BUF_KEEP_WIDTH-1:0]         m_outbuf_axis_tkeep,
  output logic                              m_outbuf_axis_tlast,
  output logic                              m_outbuf_axis_tvalid,
  input  logic                              m_outbuf_axis_tready,
  output logic [EXTRACTED_STRUCT_WIDTH-1:0] m_extracted_axis_tdata,
  output logic                              m_extracted_axis_tvalid,
`ifdef EXTRACT_LEN_CHECK_EN
  output logic                              m_extracted_axis_tuser,
  output logic [15:0]                       short_pkt_cnt,
`endif
  input  logic                              m_extracted_axis_tready
);

  // state   | meaning
  // ST_HDR  | collecting header beats into the accumulator
  // ST_BODY | struct already captured, forwarding the rest of the packet
  localparam logic [0:0] ST_HDR  = 1'b0;
  localparam logic [0:0] ST_BODY = 1'b1;

  localparam int HDR_BEATS = (EXTRACT_OFFSET*8 + EXTRACTED_STRUCT_WIDTH + BUF_DATA_WIDTH - 1)
                             / BUF_DATA_WIDTH;
  localparam int ACC_W = HDR_BEATS * BUF_DATA_WIDTH;
  localparam int CNT_W = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
  localparam int PTR_W = $clog2(STRUCT_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_HDR = CNT_W'(HDR_BEATS - 1);
  localparam logic [PTR_W:0]   FIFO_FULL_CNT = (PTR_W+1)'(STRUCT_FIFO_DEPTH);

  logic [0:0]                        state;
  logic [CNT_W-1:0]                  beat_cnt;
  logic [ACC_W-1:0]                  acc;
  logic [ACC_W-1:0]                  acc_merged;
  logic [BUF_DATA_WIDTH-1:0]         beat_masked;
  logic [EXTRACTED_STRUCT_WIDTH-1:0] struct_word;

  logic [EXTRACTED_STRUCT_WIDTH-1:0] fifo_mem [STRUCT_FIFO_DEPTH];
  logic [PTR_W-1:0]                  wr_ptr;
  logic [PTR_W-1:0]                  rd_ptr;
  logic [PTR_W:0]                    fifo_cnt;

  logic in_hdr;
  logic cap_cond;
  logic fifo_full;
  logic push;
  logic pop;
  logic stall;
  logic xfer;

  assign in_hdr    = (state == ST_HDR);
  assign cap_cond  = in_hdr & ((beat_cnt == LAST_HDR) | s_inbuf_axis_tlast);
  assign fifo_full = (fifo_cnt == FIFO_FULL_CNT);
  assign m_extracted_axis_tvalid = (fifo_cnt != '0);
  assign pop       = m_extracted_axis_tvalid & m_extracted_axis_tready;
  // A same-cycle pop frees the slot the capture needs, so it must not stall.
  assign stall     = cap_cond & fifo_full & ~pop;

  assign m_outbuf_axis_tdata  = s_inbuf_axis_tdata;
  assign m_outbuf_axis_tkeep  = s_inbuf_axis_tkeep;
  assign m_outbuf_axis_tlast  = s_inbuf_axis_tlast;
  assign m_outbuf_axis_tvalid = s_inbuf_axis_tvalid & ~stall;
  assign s_inbuf_axis_tready  = m_outbuf_axis_tready & ~stall;

  assign xfer = s_inbuf_axis_tvalid & s_inbuf_axis_tready;
  assign push = xfer & cap_cond;

  always_comb begin
    beat_masked = '0;
    for (int i = 0; i < BUF_KEEP_WIDTH; i++) begin
      beat_masked[i*8 +: 8] = s_inbuf_axis_tkeep[i] ? s_inbuf_axis_tdata[i*8 +: 8] : 8'h00;
    end
  end

  // Current beat merged into its slot so the capture beat contributes in the same cycle.
  always_comb begin
    acc_merged = acc;
    for (int i = 0; i < HDR_BEATS; i++) begin
      if (beat_cnt == CNT_W'(i)) begin
        acc_merged[i*BUF_DATA_WIDTH +: BUF_DATA_WIDTH] = beat_masked;
      end
    end
  end

  assign struct_word = acc_merged[EXTRACT_OFFSET*8 +: EXTRACTED_STRUCT_WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_HDR;
      beat_cnt <= '0;
      acc      <= '0;
    end else if (xfer) begin
      case (state)
        ST_HDR: begin
          if (cap_cond && s_inbuf_axis_tlast) begin
            beat_cnt <= '0;
            acc      <= '0;
          end else if (cap_cond) begin
            state <= ST_BODY;
            acc   <= acc_merged;
          end else begin
            acc      <= acc_merged;
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        ST_BODY: begin
          if (s_inbuf_axis_tlast) begin
            state    <= ST_HDR;
            beat_cnt <= '0;
            acc      <= '0;
          end
        end
        default: begin
          state    <= ST_HDR;
          beat_cnt <= '0;
          acc      <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= struct_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign m_extracted_axis_tdata = fifo_mem[rd_ptr];

`ifdef EXTRACT_LEN_CHECK_EN
  localparam int END_BYTE = EXTRACT_OFFSET + EXTRACTED_STRUCT_WIDTH/8;
  localparam int BYTE_W   = $clog2(HDR_BEATS*BUF_KEEP_WIDTH + 1) + 1;

  logic [BYTE_W-1:0] byte_cnt;
  logic [BYTE_W-1:0] keep_pop;
  logic [BYTE_W:0]   byte_sum;
  logic              short_now;
  logic              fifo_user [STRUCT_FIFO_DEPTH];

  always_comb begin
    keep_pop = '0;
    for (int i = 0; i < BUF_KEEP_WIDTH; i++) begin
      keep_pop = keep_pop + BYTE_W'(s_inbuf_axis_tkeep[i]);
    end
  end

  // Only a packet that ends inside the header window can be short.
  assign byte_sum  = {1'b0, byte_cnt} + {1'b0, keep_pop};
  assign short_now = s_inbuf_axis_tlast & (byte_sum < (BYTE_W+1)'(END_BYTE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt      <= '0;
      short_pkt_cnt <= '0;
    end else begin
      if (xfer) begin
        if (!in_hdr || cap_cond) byte_cnt <= '0;
        else                     byte_cnt <= byte_sum[BYTE_W-1:0];
      end
      if (push && short_now && (short_pkt_cnt != 16'hFFFF)) begin
        short_pkt_cnt <= short_pkt_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_user[wr_ptr] <= short_now;
    end
  end

  assign m_extracted_axis_tuser = fifo_user[rd_ptr];
`endif

endmodule

// File: tb/tb_extract_multibeat.sv
// Scoreboard bench for extract_multibeat: narrow bus so the struct spans three beats at a byte offset.
module tb_extract_multibeat;

  localparam int BW    = 64;
  localparam int KW    = BW/8;
  localparam int SW    = 160;
  localparam int OFF   = 3;
  localparam int DEPTH = 4;
  localparam int HB    = (OFF*8 + SW + BW - 1) / BW;
  localparam int END_B = OFF + SW/8;
  localparam int TMO   = 2000;

  typedef struct packed {
    logic [BW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [BW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tlast = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [BW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_outbuf_tready;
  logic [SW-1:0] x_tdata;
  logic          x_tvalid;
  logic          m_ext_tready;
`ifdef EXTRACT_LEN_CHECK_EN
  logic          x_tuser;
  logic [15:0]   short_cnt;
`endif

  bit   rand_ready = 1'b0;
  logic obuf_force = 1'b1;
  logic ext_force  = 1'b0;
  logic rnd_obuf   = 1'b1;
  logic rnd_ext    = 1'b1;

  assign m_outbuf_tready = rand_ready ? rnd_obuf : obuf_force;
  assign m_ext_tready    = rand_ready ? rnd_ext  : ext_force;

  beat_t         beat_q[$];
  logic [SW-1:0] str_q[$];
  logic          usr_q[$];
  beat_t         pkt[$];
  int compared = 0, mismatched = 0;
  int pkts_sent = 0, structs_seen = 0, short_model = 0;

  always #5 clk = ~clk;

  extract_multibeat #(
    .BUF_DATA_WIDTH(BW), .BUF_KEEP_WIDTH(KW), .EXTRACTED_STRUCT_WIDTH(SW),
    .EXTRACT_OFFSET(OFF), .STRUCT_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_inbuf_axis_tdata(s_tdata), .s_inbuf_axis_tkeep(s_tkeep),
    .s_inbuf_axis_tlast(s_tlast), .s_inbuf_axis_tvalid(s_tvalid),
    .s_inbuf_axis_tready(s_tready),
    .m_outbuf_axis_tdata(m_tdata), .m_outbuf_axis_tkeep(m_tkeep),
    .m_outbuf_axis_tlast(m_tlast), .m_outbuf_axis_tvalid(m_tvalid),
    .m_outbuf_axis_tready(m_outbuf_tready),
    .m_extracted_axis_tdata(x_tdata), .m_extracted_axis_tvalid(x_tvalid),
`ifdef EXTRACT_LEN_CHECK_EN
    .m_extracted_axis_tuser(x_tuser), .short_pkt_cnt(short_cnt),
`endif
    .m_extracted_axis_tready(m_ext_tready)
  );

  always @(posedge clk) begin
    #1;
    rnd_obuf = ($urandom_range(0, 3) != 0);
    rnd_ext  = ($urandom_range(0, 1) != 0);
  end

  // Monitor: pops the scoreboard whenever either output completes a transfer.
  always @(negedge clk) begin
    if (rst) begin
      if (m_tvalid && m_outbuf_tready) begin
        compared++;
        if (beat_q.size() == 0) begin
          mismatched++;
          $display("FAIL outbuf_extra: got beat %h/%h/%b, none expected", m_tdata, m_tkeep, m_tlast);
        end else begin
          beat_t e;
          e = beat_q.pop_front();
          if ({m_tdata, m_tkeep, m_tlast} !== e) begin
            mismatched++;
            $display("FAIL outbuf_beat: got %h/%h/%b expected %h/%h/%b",
                     m_tdata, m_tkeep, m_tlast, e.d, e.k, e.l);
          end
        end
      end
      if (x_tvalid && m_ext_tready) begin
        compared++;
        structs_seen++;
        if (str_q.size() == 0) begin
          mismatched++;
          $display("FAIL struct_extra: got %h, none expected", x_tdata);
        end else begin
          logic [SW-1:0] es;
          logic          eu;
          es = str_q.pop_front();
          eu = usr_q.pop_front();
          if (x_tdata !== es) begin
            mismatched++;
            $display("FAIL struct_data: got %h expected %h", x_tdata, es);
          end
`ifdef EXTRACT_LEN_CHECK_EN
          compared++;
          if (x_tuser !== eu) begin
            mismatched++;
            $display("FAIL struct_tuser: got %b expected %b", x_tuser, eu);
          end
`else
          if (eu === 1'bx) $display("note: undefined short flag");
`endif
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: place every beat at its byte position (disabled bytes read 0) and slice the struct out.
  task automatic gen_pkt(input int nb, input logic [KW-1:0] lk);
    logic [7:0]    bytes [HB*KW];
    logic [SW-1:0] s;
    beat_t         bt;
    int            vb;
    bit            short_p;
    pkt.delete();
    vb = 0;
    foreach (bytes[i]) bytes[i] = 8'h00;
    for (int b = 0; b < nb; b++) begin
      bt.d = {$urandom, $urandom};
      bt.k = (b == nb - 1) ? lk : '1;
      bt.l = (b == nb - 1);
      for (int j = 0; j < KW; j++)
        if (b < HB && bt.k[j]) bytes[b*KW + j] = bt.d[j*8 +: 8];
      vb += $countones(bt.k);
      pkt.push_back(bt);
      beat_q.push_back(bt);
    end
    for (int k = 0; k < SW/8; k++) s[k*8 +: 8] = bytes[OFF + k];
    short_p = (nb <= HB) && (vb < END_B);
    if (short_p) short_model++;
    str_q.push_back(s);
    usr_q.push_back(short_p);
    pkts_sent++;
  endtask

  task automatic drive_pkt(input int gap_pct, input int nmax, input bit chk_lat);
    int t;
    int cap_b;
    cap_b = ((pkt.size() < HB) ? pkt.size() : HB) - 1;
    for (int b = 0; b < pkt.size() && b < nmax; b++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_tdata  = pkt[b].d;
      s_tkeep  = pkt[b].k;
      s_tlast  = pkt[b].l;
      s_tvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!s_tready) begin
        t++;
        if (t >= TMO) begin
          compared++;
          mismatched++;
          $display("FAIL input_timeout: got tready=0 for %0d cycles expected 1", t);
          s_tvalid = 1'b0;
          return;
        end
        @(negedge clk);
      end
      if (chk_lat && b == cap_b) chk("lat_before_capture", 64'(x_tvalid), 64'd0);
      @(posedge clk); #1;
      if (chk_lat && b == cap_b) chk("lat_after_capture", 64'(x_tvalid), 64'd1);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int t;
    t = 0;
    ext_force  = 1'b1;
    obuf_force = 1'b1;
    while ((str_q.size() != 0 || beat_q.size() != 0) && t < maxc) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_structs_left", 64'(str_q.size()), 64'd0);
    chk("drain_beats_left", 64'(beat_q.size()), 64'd0);
  endtask

  initial begin
    int base_s, base_p, n, m;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ext_tvalid", 64'(x_tvalid), 64'd0);
    chk("reset_outbuf_tvalid", 64'(m_tvalid), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Multi-beat capture latency, then BODY beats and a following packet.
    ext_force = 1'b0;
    gen_pkt(5, '1);
    drive_pkt(0, 99, 1'b1);
    gen_pkt(5, '1);
    drive_pkt(0, 99, 1'b0);
    drain(50);

    // Short single-beat packet: upper struct bytes must read zero.
    gen_pkt(1, 8'h0F);
    drive_pkt(0, 99, 1'b0);
    drain(50);

    // FIFO-full stall with the consumer blocked.
    ext_force = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      gen_pkt(1, '1);
      drive_pkt(0, 99, 1'b0);
    end
    gen_pkt(1, '1);
    s_tdata = pkt[0].d; s_tkeep = pkt[0].k; s_tlast = 1'b1; s_tvalid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stall_s_tready", 64'(s_tready), 64'd0);
      chk("stall_outbuf_tvalid", 64'(m_tvalid), 64'd0);
      @(posedge clk); #1;
    end
    ext_force = 1'b1;
    @(negedge clk);
    chk("pop_unstall_s_tready", 64'(s_tready), 64'd1);
    chk("pop_unstall_outbuf_tvalid", 64'(m_tvalid), 64'd1);
    @(posedge clk); #1;
    ext_force = 1'b0;
    s_tvalid  = 1'b0;
    @(negedge clk);
    chk("full_after_pushpop", 64'(x_tvalid), 64'd1);
    @(posedge clk); #1;
    gen_pkt(1, '1);
    ext_force = 1'b1;
    drive_pkt(0, 99, 1'b0);
    drain(50);

    // Reset mid-packet while structs are queued.
    ext_force = 1'b0;
    gen_pkt(1, '1);  drive_pkt(0, 99, 1'b0);
    gen_pkt(2, '1);  drive_pkt(0, 99, 1'b0);
    gen_pkt(6, '1);  drive_pkt(0, 4, 1'b0);
    rst = 1'b0;
    #1;
    chk("midreset_ext_tvalid", 64'(x_tvalid), 64'd0);
    str_q.delete(); usr_q.delete(); beat_q.delete();
    short_model = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    gen_pkt(3, '1);
    drive_pkt(0, 99, 1'b0);
    drain(50);

    // Randomised traffic with random backpressure on both outputs.
    base_s = structs_seen;
    base_p = pkts_sent;
    rand_ready = 1'b1;
    for (int p = 0; p < 200; p++) begin
      n = $urandom_range(1, KW);
      m = (1 << n) - 1;
      gen_pkt($urandom_range(1, 6), m[KW-1:0]);
      drive_pkt(30, 99, 1'b0);
    end
    rand_ready = 1'b0;
    drain(500);
    chk("random_struct_count", 64'(structs_seen - base_s), 64'(pkts_sent - base_p));
`ifdef EXTRACT_LEN_CHECK_EN
    chk("short_pkt_cnt", 64'(short_cnt), 64'(short_model));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
